// File: rtl/condicionador_botoes.sv
// rtl/condicionador_botoes.sv - button synchronizer, debouncer and single-cycle press pulse generator
// Optional CONDICIONADOR_SERIALIZE_EN: issue at most one pulse bit per cycle, lowest index first.
module condicionador_botoes #(
   parameter int N               = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] btn_raw,
   input  logic         enable,
   output logic [N-1:0] pulsos,
   output logic [N-1:0] estado
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [N-1:0]  pressed_raw;
   logic [N-1:0]  sync1_q, sync2_q;
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [N-1:0]  estado_q, estado_d;
   logic [N-1:0]  estado_prev_q;
   logic [N-1:0]  rise;
   logic [N-1:0]  pulsos_q, pulsos_d;

   assign pressed_raw = btn_raw ^ {N{ACTIVE_LOW}};
   assign rise        = estado_q & ~estado_prev_q;

   // The counter only runs while the synchronized level disagrees with the
   // accepted level; reaching the last count accepts the new level.
   always_comb begin
      estado_d = estado_q;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != estado_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               estado_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

`ifdef CONDICIONADOR_SERIALIZE_EN
   logic [N-1:0] pendente_q, pendente_d;
   logic [N-1:0] pend_all, grant;

   // Lowest set bit of the pending set: x & -x.
   always_comb begin
      pend_all = pendente_q | rise;
      grant    = pend_all & (~pend_all + N'(1));
      if (enable) begin
         pulsos_d   = grant;
         pendente_d = pend_all & ~grant;
      end else begin
         pulsos_d   = '0;
         pendente_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pendente_q <= '0;
      else     pendente_q <= pendente_d;
   end
`else
   always_comb begin
      pulsos_d = rise & {N{enable}};
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         estado_q      <= '0;
         estado_prev_q <= '0;
         pulsos_q      <= '0;
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q       <= pressed_raw;
         sync2_q       <= sync1_q;
         estado_q      <= estado_d;
         estado_prev_q <= estado_q;
         pulsos_q      <= pulsos_d;
         for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign pulsos = pulsos_q;
   assign estado = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// tb/tb_condicionador_botoes.sv - randomized and directed bench with a history-based reference model
module tb_condicionador_botoes;
   localparam int N = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b1;
   logic [N-1:0] btn_raw = 8'hFF;
   logic [N-1:0] pulsos, estado;

   condicionador_botoes #(.N(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw), .enable(enable),
      .pulsos(pulsos), .estado(estado)
   );

   always #5 clk = ~clk;

   // Model: hist[k] is the pressed sample taken k edges ago.
   logic [N-1:0] hist [0:D+1];
   logic [N-1:0] m_est, m_est_prev, m_pul, m_pend;
   int n_cmp = 0, n_err = 0;
   int edge_n = 0, last_pulse_edge = 0, nz_cycles = 0;
   int pulse_cnt [N];
   logic [N-1:0] first_p, second_p;

   task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @edge %0d: got %h expected %h", tag, edge_n, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k <= D + 1; k++) hist[k] = '0;
      m_est = '0; m_est_prev = '0; m_pul = '0; m_pend = '0;
   endtask

   // A level is accepted once the D samples seen by the debouncer all disagree with it.
   task automatic model_edge(input logic [N-1:0] b, input logic en);
      logic [N-1:0] rise, nxt, all_p;
      logic flip, found;
      rise = m_est & ~m_est_prev;
      for (int k = D + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ~b;
      for (int c = 0; c < N; c++) begin
         flip = 1'b1;
         for (int k = 2; k <= D + 1; k++) if (hist[k][c] == m_est[c]) flip = 1'b0;
         nxt[c] = flip ? ~m_est[c] : m_est[c];
      end
`ifdef CONDICIONADOR_SERIALIZE_EN
      all_p = m_pend | rise;
      m_pul = '0;
      found = 1'b0;
      if (en) begin
         for (int c = 0; c < N; c++) if (all_p[c] && !found) begin
            m_pul[c] = 1'b1; found = 1'b1;
         end
         m_pend = all_p & ~m_pul;
      end else begin
         m_pend = '0;
      end
`else
      all_p = '0; found = 1'b0;
      m_pul = en ? rise : '0;
`endif
      m_est_prev = m_est;
      m_est = nxt;
   endtask

   task automatic step(input logic [N-1:0] b, input logic en, input logic r);
      @(negedge clk);
      btn_raw = b; enable = en; rst = r;
      @(posedge clk);
      #1;
      edge_n++;
      if (rst) model_reset();
      else     model_edge(b, en);
      check("estado", estado, m_est);
      check("pulsos", pulsos, m_pul);
      for (int c = 0; c < N; c++) if (pulsos[c]) pulse_cnt[c]++;
      if (pulsos != '0) begin
         last_pulse_edge = edge_n;
         nz_cycles++;
         if (nz_cycles == 1) first_p = pulsos;
         if (nz_cycles == 2) second_p = pulsos;
      end
   endtask

   task automatic clear_stats();
      for (int c = 0; c < N; c++) pulse_cnt[c] = 0;
      nz_cycles = 0; first_p = '0; second_p = '0; last_pulse_edge = 0;
   endtask

   task automatic hold(input logic [N-1:0] b, input int n);
      for (int i = 0; i < n; i++) step(b, 1'b1, 1'b0);
   endtask

   int e0;
   logic [N-1:0] rb;
   logic ren, rrst;

   initial begin
      model_reset();
      clear_stats();
      #1;
      check("reset_pulsos", pulsos, '0);
      check("reset_estado", estado, '0);
      for (int i = 0; i < 3; i++) step(8'hFF, 1'b1, 1'b1);
      hold(8'hFF, 3);

      // Clean press on channel 3
      clear_stats();
      e0 = edge_n + 1;
      hold(8'hF7, 14);
      check("clean_cnt", 8'(pulse_cnt[3]), 8'd1);
      check("clean_lat", 8'(last_pulse_edge - e0), 8'd6);
      check("clean_val", first_p, 8'h08);
      hold(8'hFF, 12);
      check("release_cnt", 8'(pulse_cnt[3]), 8'd1);

      // Bounce on channel 0: 3-cycle runs, then stable press
      clear_stats();
      for (int i = 0; i < 30; i++) step(((i / 3) % 2 == 0) ? 8'hFE : 8'hFF, 1'b1, 1'b0);
      check("bounce_none", 8'(pulse_cnt[0]), 8'd0);
      hold(8'hFE, 12);
      check("bounce_cnt", 8'(pulse_cnt[0]), 8'd1);
      hold(8'hFF, 12);

      // Enable gating on channel 5
      clear_stats();
      for (int i = 0; i < 10; i++) step(8'hDF, 1'b0, 1'b0);
      hold(8'hDF, 8);
      check("gated_cnt", 8'(pulse_cnt[5]), 8'd0);
      hold(8'hFF, 10);
      hold(8'hDF, 10);
      check("regated_cnt", 8'(pulse_cnt[5]), 8'd1);
      check("regated_val", first_p, 8'h20);
      hold(8'hFF, 12);

      // Reset two cycles into a press on channel 2
      clear_stats();
      hold(8'hFB, 2);
      for (int i = 0; i < 3; i++) step(8'hFB, 1'b1, 1'b1);
      check("rst_pulsos", pulsos, '0);
      check("rst_estado", estado, '0);
      e0 = edge_n + 1;
      hold(8'hFB, 12);
      check("rst_cnt", 8'(pulse_cnt[2]), 8'd1);
      check("rst_lat", 8'(last_pulse_edge - e0), 8'd6);
      hold(8'hFF, 12);

      // Simultaneous presses on channels 1 and 6
      clear_stats();
      hold(8'hBD, 14);
`ifdef CONDICIONADOR_SERIALIZE_EN
      check("simul_first", first_p, 8'h02);
      check("simul_second", second_p, 8'h40);
      check("simul_cycles", 8'(nz_cycles), 8'd2);
`else
      check("simul_first", first_p, 8'h42);
      check("simul_cycles", 8'(nz_cycles), 8'd1);
`endif
      hold(8'hFF, 12);

      // Glitch on channel 7
      clear_stats();
      hold(8'h7F, 3);
      hold(8'hFF, 10);
      check("glitch_cnt", 8'(pulse_cnt[7]), 8'd0);

      // Random stimulus with sticky buttons, occasional disable and reset
      rb = 8'hFF;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < N; c++) if ($urandom_range(0, 9) == 0) rb[c] = ~rb[c];
         ren  = ($urandom_range(0, 7) != 0);
         rrst = ($urandom_range(0, 299) == 0);
         step(rb, ren, rrst);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
